// File: rtl/uart_pkt_tx_arbiter.sv
// Round-robin arbiter that frames one requester's packet at a time onto a shared uart_tx.
// Optional checksum byte (XOR of CMD, LEN and payload) enabled by defining PKT_CHECKSUM_EN.
module uart_pkt_tx_arbiter #(
  parameter int          NREQ       = 4,
  parameter int          DATA_BYTES = 4,
  parameter logic [7:0]  START_BYTE = 8'hFF
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NREQ-1:0]              REQ,
  input  logic [8*NREQ-1:0]            REQ_CMD,
  input  logic [8*NREQ-1:0]            REQ_LEN,
  input  logic [8*DATA_BYTES*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]              ACK,
  output logic [$clog2(NREQ)-1:0]      GRANT_ID,
  output logic                         BUSY,
  output logic                         TX_START,
  output logic [7:0]                   TX_DATA,
  input  logic                         TX_BUSY
);

  localparam int GW = $clog2(NREQ);
  localparam int DW = 8 * DATA_BYTES;
`ifdef PKT_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int IW = $clog2(DATA_BYTES + 5);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_ack;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr;
  logic            r_busy;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_cmd;
  logic [7:0]      r_len;
  logic [DW-1:0]   r_data;
  logic [IW-1:0]   r_idx;

  logic [2*NREQ-1:0] w_req2;
  logic              w_any;
  logic [GW:0]       w_sum;
  logic [GW-1:0]     w_win;
  logic [GW-1:0]     w_next_rr;
  logic [NREQ-1:0]   w_onehot;
  logic [7:0]        w_cmd;
  logic [7:0]        w_len_raw;
  logic [7:0]        w_len_clamp;
  logic [DW-1:0]     w_data;
  logic [7:0]        w_byte;
  logic [7:0]        w_csum;
  logic [IW-1:0]     w_last;

  // Rotate the doubled request vector so bit 0 is the rr pointer; first set bit wins.
  always_comb begin
    w_req2 = {REQ, REQ} >> r_rr;
    w_any  = 1'b0;
    w_sum  = '0;
    w_win  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any && w_req2[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_rr} + (GW+1)'(k);
        if (w_sum >= (GW+1)'(NREQ)) begin
          w_sum = w_sum - (GW+1)'(NREQ);
        end
        w_win = w_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    w_next_rr = (w_win == GW'(NREQ - 1)) ? '0 : w_win + GW'(1);
    w_onehot  = NREQ'(1) << w_win;
  end

  always_comb begin
    w_cmd     = '0;
    w_len_raw = '0;
    w_data    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_win == GW'(k)) begin
        w_cmd     = REQ_CMD[k*8 +: 8];
        w_len_raw = REQ_LEN[k*8 +: 8];
        w_data    = REQ_DATA[k*DW +: DW];
      end
    end
    w_len_clamp = (w_len_raw > 8'(DATA_BYTES)) ? 8'(DATA_BYTES) : w_len_raw;
  end

  always_comb begin
    w_csum = r_cmd ^ r_len;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (8'(k) < r_len) begin
        w_csum = w_csum ^ r_data[k*8 +: 8];
      end
    end
  end

  // Byte index: 0 start, 1 cmd, 2 len, 3.. payload, then optional checksum.
  always_comb begin
    w_byte = START_BYTE;
    if (r_idx == IW'(1)) begin
      w_byte = r_cmd;
    end else if (r_idx == IW'(2)) begin
      w_byte = r_len;
    end
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (r_idx == IW'(k + 3)) begin
        w_byte = r_data[k*8 +: 8];
      end
    end
`ifdef PKT_CHECKSUM_EN
    if (r_idx == IW'(r_len) + IW'(3)) begin
      w_byte = w_csum;
    end
`endif
    w_last = IW'(r_len) + IW'(2 + EXTRA);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_grant    <= '0;
      r_rr       <= '0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_cmd      <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_idx      <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cmd   <= w_cmd;
            r_len   <= w_len_clamp;
            r_data  <= w_data;
            r_grant <= w_win;
            r_ack   <= w_onehot;
            r_busy  <= 1'b1;
            r_rr    <= w_next_rr;
            r_idx   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (!TX_BUSY) begin
            r_tx_data  <= w_byte;
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (TX_BUSY) begin
            r_tx_start <= 1'b0;
            r_state    <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!TX_BUSY) begin
            if (r_idx == w_last) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= S_START;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ACK      = r_ack;
  assign GRANT_ID = r_grant;
  assign BUSY     = r_busy;
  assign TX_START = r_tx_start;
  assign TX_DATA  = r_tx_data;

endmodule

// File: tb/tb_uart_pkt_tx_arbiter.sv
// Directed bench for uart_pkt_tx_arbiter with a behavioural uart_tx handshake model.
module tb_uart_pkt_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] REQ_CMD;
  logic [31:0] REQ_LEN;
  logic [127:0] REQ_DATA;
  logic [3:0]  ACK;
  logic [1:0]  GRANT_ID;
  logic        BUSY;
  logic        TX_START;
  logic [7:0]  TX_DATA;
  logic        TX_BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  uart_pkt_tx_arbiter #(
    .NREQ(4),
    .DATA_BYTES(4),
    .START_BYTE(8'hFF)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .REQ(REQ),
    .REQ_CMD(REQ_CMD),
    .REQ_LEN(REQ_LEN),
    .REQ_DATA(REQ_DATA),
    .ACK(ACK),
    .GRANT_ID(GRANT_ID),
    .BUSY(BUSY),
    .TX_START(TX_START),
    .TX_DATA(TX_DATA),
    .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  // uart_tx model: accepts TX_START, raises busy after m_dly cycles, holds it m_hold cycles.
  logic [7:0] q_bytes[$];
  int         m_dly   = 0;
  int         m_hold  = 3;
  int         m_st    = 0;
  int         m_cnt   = 0;
  int         m_viol  = 0;
  int         m_falls = 0;
  logic [7:0] m_cap;

  initial TX_BUSY = 1'b0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      TX_BUSY <= 1'b0;
      m_st = 0;
    end else begin
      case (m_st)
        0: if (TX_START === 1'b1) begin
             m_cap = TX_DATA;
             q_bytes.push_back(TX_DATA);
             m_cnt = m_dly;
             m_st  = 1;
           end
        1: begin
             if (TX_START !== 1'b1 || TX_DATA !== m_cap) m_viol++;
             if (m_cnt == 0) begin
               TX_BUSY <= 1'b1;
               m_cnt = m_hold;
               m_st  = 2;
             end else m_cnt--;
           end
        2: if (m_cnt == 0) begin
             TX_BUSY <= 1'b0;
             m_falls++;
             m_st = 3;
           end else m_cnt--;
        default: m_st = 0;
      endcase
    end
  end

  task automatic wait_busy_low(input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      @(negedge CLK);
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      @(negedge CLK);
      if (ACK[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    REQ = '0; REQ_CMD = '0; REQ_LEN = '0; REQ_DATA = '0;
    repeat (3) @(negedge CLK);
    n_checks++; if (ACK !== 4'b0) $display("FAIL reset_ack got=%b exp=0000", ACK); else n_pass++;
    n_checks++; if (GRANT_ID !== 2'd0) $display("FAIL reset_grant got=%0d exp=0", GRANT_ID); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY); else n_pass++;
    n_checks++; if (TX_START !== 1'b0) $display("FAIL reset_txstart got=%b exp=0", TX_START); else n_pass++;
    n_checks++; if (TX_DATA !== 8'h00) $display("FAIL reset_txdata got=%h exp=00", TX_DATA); else n_pass++;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single;
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok;
    int f0;
    exp = '{8'hFF, 8'h00, 8'h01, 8'h0A};
`ifdef PKT_CHECKSUM_EN
    exp.push_back(8'h0B);
`endif
    q_bytes.delete();
    f0 = m_falls;
    REQ_CMD[15:8] = 8'h00; REQ_LEN[15:8] = 8'h01; REQ_DATA[63:32] = 32'h0000000A;
    REQ = 4'b0010;
    @(negedge CLK);
    n_checks++; if (ACK !== 4'b0010) $display("FAIL single_ack got=%b exp=0010", ACK); else n_pass++;
    n_checks++; if (GRANT_ID !== 2'd1) $display("FAIL single_grant got=%0d exp=1", GRANT_ID); else n_pass++;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL single_busy got=%b exp=1", BUSY); else n_pass++;
    REQ = 4'b0000;
    @(negedge CLK);
    n_checks++; if (ACK !== 4'b0000) $display("FAIL single_ack_pulse got=%b exp=0000", ACK); else n_pass++;
    wait_busy_low(2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_timeout got=%b exp=1", ok); else n_pass++;
    n_checks++; if (m_falls - f0 !== exp.size()) $display("FAIL single_falls got=%0d exp=%0d", m_falls - f0, exp.size()); else n_pass++;
    n_checks++; if (q_bytes.size() !== exp.size()) $display("FAIL single_nbytes got=%0d exp=%0d", q_bytes.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
      n_checks++; if (got !== exp[i]) $display("FAIL single_byte%0d got=%h exp=%h", i, got, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp[$];
    logic [7:0] got;
    logic [1:0] grants[$];
    logic [1:0] exp_g[5];
    int run, maxgap;
    bit ok;
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int f = 0; f < 5; f++) begin
      exp.push_back(8'hFF);
      exp.push_back(8'h10 + 8'(exp_g[f]));
      exp.push_back(8'h00);
`ifdef PKT_CHECKSUM_EN
      exp.push_back(8'h10 + 8'(exp_g[f]));
`endif
    end
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    q_bytes.delete();
    for (int i = 0; i < 4; i++) begin
      REQ_CMD[8*i +: 8] = 8'h10 + 8'(i);
      REQ_LEN[8*i +: 8] = 8'h00;
    end
    REQ = 4'b1111;
    run = 0; maxgap = 0;
    repeat (3000) begin
      @(negedge CLK);
      if (grants.size() >= 1) begin
        if (BUSY === 1'b0) run++;
        else begin
          if (run > maxgap) maxgap = run;
          run = 0;
        end
      end
      if (ACK !== 4'b0000) begin
        grants.push_back(GRANT_ID);
        if (grants.size() == 5) begin
          REQ = 4'b0000;
          break;
        end
      end
    end
    wait_busy_low(2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rr_timeout got=%b exp=1", ok); else n_pass++;
    n_checks++; if (grants.size() !== 5) $display("FAIL rr_ngrants got=%0d exp=5", grants.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      got = (i < grants.size()) ? 8'(grants[i]) : 8'hxx;
      n_checks++; if (got !== 8'(exp_g[i])) $display("FAIL rr_grant%0d got=%0d exp=%0d", i, got, exp_g[i]); else n_pass++;
    end
    n_checks++; if (maxgap > 1) $display("FAIL rr_gap got=%0d exp<=1", maxgap); else n_pass++;
    n_checks++; if (q_bytes.size() !== exp.size()) $display("FAIL rr_nbytes got=%0d exp=%0d", q_bytes.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
      n_checks++; if (got !== exp[i]) $display("FAIL rr_byte%0d got=%h exp=%h", i, got, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_len_clamp;
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok;
    exp = '{8'hFF, 8'h5A, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef PKT_CHECKSUM_EN
    exp.push_back(8'h1A);
`endif
    q_bytes.delete();
    REQ_CMD[23:16] = 8'h5A; REQ_LEN[23:16] = 8'h07; REQ_DATA[95:64] = 32'h44332211;
    REQ = 4'b0100;
    wait_ack(2, 50, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL clamp_ack got=%b exp=1", ok); else n_pass++;
    n_checks++; if (GRANT_ID !== 2'd2) $display("FAIL clamp_grant got=%0d exp=2", GRANT_ID); else n_pass++;
    REQ = 4'b0000;
    wait_busy_low(2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL clamp_timeout got=%b exp=1", ok); else n_pass++;
    n_checks++; if (q_bytes.size() !== exp.size()) $display("FAIL clamp_nbytes got=%0d exp=%0d", q_bytes.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
      n_checks++; if (got !== exp[i]) $display("FAIL clamp_byte%0d got=%h exp=%h", i, got, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_slow_uart;
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok;
    int v0, run, maxrun;
    exp = '{8'hFF, 8'h77, 8'h02, 8'hAA, 8'hBB};
`ifdef PKT_CHECKSUM_EN
    exp.push_back(8'h64);
`endif
    q_bytes.delete();
    m_dly = 5;
    v0 = m_viol;
    REQ_CMD[31:24] = 8'h77; REQ_LEN[31:24] = 8'h02; REQ_DATA[127:96] = 32'h0000BBAA;
    REQ = 4'b1000;
    wait_ack(3, 50, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL slow_ack got=%b exp=1", ok); else n_pass++;
    REQ = 4'b0000;
    ok = 1'b0; run = 0; maxrun = 0;
    repeat (3000) begin
      @(negedge CLK);
      if (TX_START === 1'b1) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    m_dly = 0;
    n_checks++; if (ok !== 1'b1) $display("FAIL slow_timeout got=%b exp=1", ok); else n_pass++;
    n_checks++; if (m_viol - v0 !== 0) $display("FAIL slow_stable got=%0d violations exp=0", m_viol - v0); else n_pass++;
    n_checks++; if (maxrun < 6) $display("FAIL slow_hold got=%0d cycles exp>=6", maxrun); else n_pass++;
    n_checks++; if (q_bytes.size() !== exp.size()) $display("FAIL slow_nbytes got=%0d exp=%0d", q_bytes.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
      n_checks++; if (got !== exp[i]) $display("FAIL slow_byte%0d got=%h exp=%h", i, got, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok;
    exp = '{8'hFF, 8'h42, 8'h00};
`ifdef PKT_CHECKSUM_EN
    exp.push_back(8'h42);
`endif
    q_bytes.delete();
    REQ_CMD[7:0] = 8'h31; REQ_LEN[7:0] = 8'h03; REQ_DATA[31:0] = 32'h00CCBBAA;
    REQ = 4'b0001;
    wait_ack(0, 50, ok);
    REQ = 4'b0000;
    n_checks++; if (ok !== 1'b1) $display("FAIL rmid_ack got=%b exp=1", ok); else n_pass++;
    ok = 1'b0;
    repeat (2000) begin
      @(negedge CLK);
      if (q_bytes.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (ok !== 1'b1) $display("FAIL rmid_reach got=%b exp=1", ok); else n_pass++;
    n_checks++; if (q_bytes.size() > 4 && q_bytes[4] !== 8'hBB) $display("FAIL rmid_byte4 got=%h exp=bb", q_bytes[4]); else n_pass++;
    RST_N = 1'b0;
    @(negedge CLK);
    n_checks++; if (TX_START !== 1'b0) $display("FAIL rmid_txstart got=%b exp=0", TX_START); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", BUSY); else n_pass++;
    n_checks++; if (ACK !== 4'b0000) $display("FAIL rmid_ack_after got=%b exp=0000", ACK); else n_pass++;
    RST_N = 1'b1;
    @(negedge CLK);
    q_bytes.delete();
    REQ_CMD[23:16] = 8'h42; REQ_LEN[23:16] = 8'h00;
    REQ = 4'b0100;
    wait_ack(2, 50, ok);
    REQ = 4'b0000;
    n_checks++; if (ok !== 1'b1) $display("FAIL rmid_new_ack got=%b exp=1", ok); else n_pass++;
    n_checks++; if (GRANT_ID !== 2'd2) $display("FAIL rmid_new_grant got=%0d exp=2", GRANT_ID); else n_pass++;
    wait_busy_low(2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rmid_timeout got=%b exp=1", ok); else n_pass++;
    n_checks++; if (q_bytes.size() !== exp.size()) $display("FAIL rmid_nbytes got=%0d exp=%0d", q_bytes.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
      n_checks++; if (got !== exp[i]) $display("FAIL rmid_byte%0d got=%h exp=%h", i, got, exp[i]); else n_pass++;
    end
  endtask

`ifdef PKT_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] exp[$];
    logic [7:0] got;
    bit ok;
    exp = '{8'hFF, 8'h03, 8'h02, 8'h01, 8'h02, 8'h02};
    q_bytes.delete();
    REQ_CMD[15:8] = 8'h03; REQ_LEN[15:8] = 8'h02; REQ_DATA[63:32] = 32'h00000201;
    REQ = 4'b0010;
    wait_ack(1, 50, ok);
    REQ = 4'b0000;
    n_checks++; if (ok !== 1'b1) $display("FAIL csum_ack got=%b exp=1", ok); else n_pass++;
    wait_busy_low(2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL csum_timeout got=%b exp=1", ok); else n_pass++;
    n_checks++; if (q_bytes.size() !== exp.size()) $display("FAIL csum_nbytes got=%0d exp=%0d", q_bytes.size(), exp.size()); else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < q_bytes.size()) ? q_bytes[i] : 8'hxx;
      n_checks++; if (got !== exp[i]) $display("FAIL csum_byte%0d got=%h exp=%h", i, got, exp[i]); else n_pass++;
    end
  endtask
`endif

  initial begin
    RST_N = 1'b0;
    REQ = '0; REQ_CMD = '0; REQ_LEN = '0; REQ_DATA = '0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_round_robin();
    test_len_clamp();
    test_slow_uart();
    test_reset_mid();
`ifdef PKT_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
